// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the bit-serial subtractor.
//   - ST_* : state encoding of the serial_sub controller (2'd3 is unused and
//            decodes as IDLE).
//   - state_t : enumerated controller state built on that encoding.
//   - cnt_width() : width of the bit counter for a given operand width.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Counter must hold 0..w-1 without wrapping; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// fs_cell: combinational 1-bit full subtractor, computes x - y - c.
// Ports:
//   i_x  in  1  minuend bit
//   i_y  in  1  subtrahend bit
//   i_c  in  1  borrow in
//   o_di out 1  difference bit
//   o_bo out 1  borrow out
module fs_cell
  import arith_pkg::*;
(
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_di,
  output logic o_bo
);

  assign o_di = i_x ^ i_y ^ i_c;
  assign o_bo = (~i_x & i_y) | (~i_x & i_c) | (i_y & i_c);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, diff = a - b - bin, one bit
// per clock, LSB first, using a single fs_cell and a registered borrow.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   start in  1      request, accepted only while ready=1
//   a     in  WIDTH  minuend, sampled on the accepting edge
//   b     in  WIDTH  subtrahend, sampled on the accepting edge
//   bin   in  1      borrow in, sampled on the accepting edge
//   ready out 1      controller idle
//   busy  out 1      operation shifting
//   done  out 1      one-cycle completion pulse
//   diff  out WIDTH  result mod 2^WIDTH, held until the next completion
//   bout  out 1      final borrow (unsigned a < b + bin)
//   ovf   out 1      signed overflow of a - b - bin
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] w_res_next;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             w_di;
  logic             w_bo;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  fs_cell u_cell (
    .i_x  (r_a_sr[0]),
    .i_y  (r_b_sr[0]),
    .i_c  (r_brw),
    .o_di (w_di),
    .o_bo (w_bo)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has landed in position 0.
  assign w_res_next = {w_di, r_res_sr[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        // Covers S_IDLE and the unused encoding, which is folded into IDLE.
        w_ready      = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_ready && start) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_brw    <= bin;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
    end else if (w_busy) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_next;
      r_brw    <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        // Published results only move here, so RUN never exposes partials.
        // The final di is the result MSB, hence its use for overflow.
        r_diff <= w_res_next;
        r_bout <= w_bo;
        r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_di);
      end
    end
  end

  assign ready = w_ready;
  assign busy  = w_busy;
  assign done  = w_done;
  assign diff  = r_diff;
  assign bout  = r_bout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  logic cx = 1'b0;
  logic cy = 1'b0;
  logic cc = 1'b0;
  logic cdi;
  logic cbo;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] prev_diff = '0;
  logic             prev_bout = 1'b0;
  logic             prev_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  fs_cell u_cell_tb (
    .i_x  (cx),
    .i_y  (cy),
    .i_c  (cc),
    .o_di (cdi),
    .o_bo (cbo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, returns {ovf,bout,diff}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic mbin);
    int ud;
    int sd;
    logic [31:0] udv;
    logic r_ov;
    logic r_bo;
    ud  = int'(ma) - int'(mb) - int'(mbin);
    sd  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    udv = ud;
    r_bo = (ud < 0);
    r_ov = (sd < -(1 << (WIDTH - 1))) || (sd > ((1 << (WIDTH - 1)) - 1));
    return {r_ov, r_bo, udv[WIDTH-1:0]};
  endfunction

  // One full operation. With inject set, start is pulsed mid-RUN (with
  // different operands) and again during DONE; neither may be accepted.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin, input bit inject, input bit verbose);
    logic [WIDTH+1:0] m;
    int n;
    bit stable;
    m = model(ia, ib, ibin);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    n = 1;
    stable = 1'b1;
    while (!done && n < 40) begin
      if (diff !== prev_diff || bout !== prev_bout || ovf !== prev_ovf || busy !== 1'b1 || ready !== 1'b0)
        stable = 1'b0;
      if (inject && n == 4) begin
        start = 1'b1;
        a = ~ia;
        b = ~ib;
      end
      if (inject && n == 5) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'(WIDTH + 1));
    check("run_outputs_stable", 32'(stable), 32'd1);
    check("diff", 32'(diff), 32'(m[WIDTH-1:0]));
    check("bout", 32'(bout), 32'(m[WIDTH]));
    check("ovf", 32'(ovf), 32'(m[WIDTH+1]));
    check("ready_busy_in_done", 32'({ready, busy}), 32'd0);
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_done_flags", 32'({done, busy, ready}), 32'b001);
    check("diff_held", 32'(diff), 32'(m[WIDTH-1:0]));
    if (verbose)
      $display("op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d (exp %02h %0d %0d)",
               ia, ib, ibin, diff, bout, ovf, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
    prev_diff = m[WIDTH-1:0];
    prev_bout = m[WIDTH];
    prev_ovf  = m[WIDTH+1];
  endtask

  initial begin
    int ndone;
    int r;

    // fs_cell truth table against x - y - c
    for (int i = 0; i < 8; i++) begin
      {cx, cy, cc} = 3'(i);
      #1;
      r = int'(cx) - int'(cy) - int'(cc);
      check("fs_cell_di", 32'(cdi), 32'(r & 1));
      check("fs_cell_bo", 32'(cbo), 32'(r < 0));
      $display("fs_cell x=%0d y=%0d c=%0d -> di=%0d bo=%0d", cx, cy, cc, cdi, cbo);
    end

    // reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_flags", 32'({ready, busy, done}), 32'b100);
    check("reset_results", 32'({ovf, bout, diff}), 32'd0);

    // directed ops
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);

    // start during RUN and DONE ignored; confirm a single done pulse overall
    run_op(8'h5A, 8'h3C, 1'b1, 1'b1, 1'b1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_extra_done", 32'(ndone), 32'd0);

    // reset mid-RUN aborts the op
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_flags", 32'({ready, busy, done}), 32'b100);
    check("midrun_reset_results", 32'({ovf, bout, diff}), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrun_reset_no_done", 32'(ndone), 32'd0);
    prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
    $display("mid-run reset -> ready=%0d diff=%02h", ready, diff);

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_together", 32'({ready, busy}), 32'b10);
    run_op(8'hC3, 8'h3C, 1'b0, 1'b0, 1'b1);

    // random ops against the reference model
    for (int i = 0; i < 1000; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (i % 50) == 7, (i % 100) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
